// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if
//   Bundles the button/switch inputs, the comparator result and every status
//   output of the round controller into one port.
//   slave  : the sequencer itself (consumes buttons, drives status)
//   master : whatever drives the buttons and observes the status
interface turn_sequencer_if #(
   parameter int NUM_CARDS = 9
);
   logic                 btn_start;
   logic                 btn_confirm;
   logic                 btn_abort;
   logic [NUM_CARDS-1:0] sw;
   logic [1:0]           match_result;
   logic [2:0]           state;
   logic                 cur_player;
   logic [NUM_CARDS-1:0] p1_card;
   logic [NUM_CARDS-1:0] p2_card;
   logic [3:0]           p1_hand;
   logic [3:0]           p2_hand;
   logic                 commit_pulse;
   logic                 err_pulse;
   logic                 score_pulse;
   logic [3:0]           round;
   logic [3:0]           p1_win;
   logic [3:0]           p2_win;
   logic [1:0]           game_result;

   modport slave (
      input  btn_start, btn_confirm, btn_abort, sw, match_result,
      output state, cur_player, p1_card, p2_card, p1_hand, p2_hand,
             commit_pulse, err_pulse, score_pulse, round, p1_win, p2_win,
             game_result
   );

   modport master (
      output btn_start, btn_confirm, btn_abort, sw, match_result,
      input  state, cur_player, p1_card, p2_card, p1_hand, p2_hand,
             commit_pulse, err_pulse, score_pulse, round, p1_win, p2_win,
             game_result
   );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer
//   Round controller for the two-player black/white card game. Holds both
//   players' available-card masks, the cards played this round, the round and
//   win counters, sequences lead/follow turns, validates switch selections,
//   samples the comparator in RESOLVE and declares the game result.
// Ports
//   clk      : system clock, all state changes on posedge
//   reset_n  : synchronous active-low reset
//   bus      : turn_sequencer_if.slave -- buttons, switches, comparator
//              result in; state, masks, hands, pulses, counters, result out
module turn_sequencer #(
   parameter int NUM_CARDS  = 9,
   parameter int MAX_ROUNDS = 9,
   parameter int WIN_TARGET = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   turn_sequencer_if.slave bus
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEAD    = 3'd1;
   localparam logic [2:0] S_FOLLOW  = 3'd2;
   localparam logic [2:0] S_RESOLVE = 3'd3;
   localparam logic [2:0] S_SHOW    = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [NUM_CARDS-1:0] FULL_MASK = '1;

   logic [2:0]           state_q,   state_d;
   logic                 cur_q,     cur_d;
   logic                 lead_q,    lead_d;
   logic [NUM_CARDS-1:0] p1_card_q, p1_card_d;
   logic [NUM_CARDS-1:0] p2_card_q, p2_card_d;
   logic [3:0]           p1_hand_q, p1_hand_d;
   logic [3:0]           p2_hand_q, p2_hand_d;
   logic [3:0]           round_q,   round_d;
   logic [3:0]           p1_win_q,  p1_win_d;
   logic [3:0]           p2_win_q,  p2_win_d;
   logic                 commit_q,  commit_d;
   logic                 err_q,     err_d;
   logic                 start_q, confirm_q, abort_q;

   logic                 start_rise, confirm_rise, abort_rise;
   logic [3:0]           sel_idx;
   logic                 sel_onehot;
   logic                 sel_ok;
   logic [NUM_CARDS-1:0] cur_mask;
   logic                 do_clear;
   logic                 game_over;

   assign start_rise   = bus.btn_start   & ~start_q;
   assign confirm_rise = bus.btn_confirm & ~confirm_q;
   assign abort_rise   = bus.btn_abort   & ~abort_q;

   // Selection decode: the index is only meaningful when the switches are
   // one-hot, which sel_ok guarantees before anything is latched.
   always_comb begin
      sel_idx = '0;
      for (int k = 0; k < NUM_CARDS; k++)
         if (bus.sw[k]) sel_idx = 4'(k);
   end

   assign sel_onehot = (bus.sw != '0) &&
                       ((bus.sw & (bus.sw - NUM_CARDS'(1))) == '0);
   assign cur_mask   = cur_q ? p2_card_q : p1_card_q;
   assign sel_ok     = sel_onehot && ((bus.sw & cur_mask) != '0);

   // Evaluated in SHOW, after RESOLVE has already bumped the counters.
   assign game_over  = (round_q == 4'(MAX_ROUNDS)) ||
                       (p1_win_q == 4'(WIN_TARGET)) ||
                       (p2_win_q == 4'(WIN_TARGET));

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      lead_d    = lead_q;
      p1_card_d = p1_card_q;
      p2_card_d = p2_card_q;
      p1_hand_d = p1_hand_q;
      p2_hand_d = p2_hand_q;
      round_d   = round_q;
      p1_win_d  = p1_win_q;
      p2_win_d  = p2_win_q;
      commit_d  = 1'b0;
      err_d     = 1'b0;
      do_clear  = 1'b0;

      if (abort_rise) begin
         state_d  = S_IDLE;
         do_clear = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               // IDLE keeps the game registers pinned at their fresh values;
               // cur_player leaves as P1 because lead is P1 here.
               do_clear = 1'b1;
               if (start_rise) state_d = S_LEAD;
            end
            S_LEAD, S_FOLLOW: begin
               if (confirm_rise) begin
                  if (sel_ok) begin
                     commit_d = 1'b1;
                     // sw is one-hot and inside the mask, so masking it off
                     // clears exactly the played card.
                     if (cur_q) begin
                        p2_card_d = p2_card_q & ~bus.sw;
                        p2_hand_d = sel_idx;
                     end else begin
                        p1_card_d = p1_card_q & ~bus.sw;
                        p1_hand_d = sel_idx;
                     end
                     if (state_q == S_LEAD) begin
                        state_d = S_FOLLOW;
                        cur_d   = ~cur_q;
                     end else begin
                        state_d = S_RESOLVE;
                     end
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_RESOLVE: begin
               round_d = round_q + 4'd1;
               if (bus.match_result == 2'b01) begin
                  p1_win_d = p1_win_q + 4'd1;
                  lead_d   = 1'b0;
               end else if (bus.match_result == 2'b10) begin
                  p2_win_d = p2_win_q + 4'd1;
                  lead_d   = 1'b1;
               end
               state_d = S_SHOW;
            end
            S_SHOW: begin
               if (confirm_rise) begin
                  if (game_over) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_LEAD;
                     cur_d   = lead_q;
                  end
               end
            end
            S_DONE: begin
               if (start_rise) begin
                  state_d  = S_IDLE;
                  do_clear = 1'b1;
               end
            end
            default: begin
               state_d  = S_IDLE;
               do_clear = 1'b1;
            end
         endcase
      end

      if (do_clear) begin
         cur_d     = 1'b0;
         lead_d    = 1'b0;
         p1_card_d = FULL_MASK;
         p2_card_d = FULL_MASK;
         p1_hand_d = '0;
         p2_hand_d = '0;
         round_d   = '0;
         p1_win_d  = '0;
         p2_win_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cur_q     <= 1'b0;
         lead_q    <= 1'b0;
         p1_card_q <= FULL_MASK;
         p2_card_q <= FULL_MASK;
         p1_hand_q <= '0;
         p2_hand_q <= '0;
         round_q   <= '0;
         p1_win_q  <= '0;
         p2_win_q  <= '0;
         commit_q  <= 1'b0;
         err_q     <= 1'b0;
         start_q   <= 1'b0;
         confirm_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         lead_q    <= lead_d;
         p1_card_q <= p1_card_d;
         p2_card_q <= p2_card_d;
         p1_hand_q <= p1_hand_d;
         p2_hand_q <= p2_hand_d;
         round_q   <= round_d;
         p1_win_q  <= p1_win_d;
         p2_win_q  <= p2_win_d;
         commit_q  <= commit_d;
         err_q     <= err_d;
         start_q   <= bus.btn_start;
         confirm_q <= bus.btn_confirm;
         abort_q   <= bus.btn_abort;
      end
   end

   assign bus.state        = state_q;
   assign bus.cur_player   = cur_q;
   assign bus.p1_card      = p1_card_q;
   assign bus.p2_card      = p2_card_q;
   assign bus.p1_hand      = p1_hand_q;
   assign bus.p2_hand      = p2_hand_q;
   assign bus.commit_pulse = commit_q;
   assign bus.err_pulse    = err_q;
   // RESOLVE lasts exactly one cycle, so this is a single-cycle pulse.
   assign bus.score_pulse  = (state_q == S_RESOLVE);
   assign bus.round        = round_q;
   assign bus.p1_win       = p1_win_q;
   assign bus.p2_win       = p2_win_q;
   assign bus.game_result  = (state_q != S_DONE)    ? 2'b00 :
                             (p1_win_q > p2_win_q)  ? 2'b01 :
                             (p1_win_q < p2_win_q)  ? 2'b10 : 2'b11;

endmodule
